pwm_cmd_sequencer: RTL and testbench

Upstream command stage for pattern_pwm. It buffers PWM job descriptors (PAT, duty_num, pulse_dessert, pulse_num) in a small synchronous FIFO and presents them one at a time on pattern_pwm's parameter inputs. It drives pattern_pwm's pwm_en with a correct level/hold discipline for both finite and infinite (pulse_num=0) modes. It uses pattern_pwm's busy to detect start and completion, then reports per-job completion, sticky errors and queue status to the control/register layer.

---
 rtl/pwm_cmd_sequencer_pkg.sv | 24 ++
 rtl/pwm_cmd_sequencer_if.sv | 23 ++
 rtl/pwm_cmd_sequencer_fifo.sv | 76 +++++++
 rtl/pwm_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_pwm_cmd_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cmd_sequencer_pkg.sv
// Shared definitions for the PWM command sequencer: FSM states and
// command field widths used by the FIFO, the interface and the top.
package pwm_seq_pkg;

    localparam int DUTY_W      = 8;
    localparam int DESSERT_W   = 16;
    localparam int PULSES_W    = 8;
    localparam int CMD_FIXED_W = DUTY_W + DESSERT_W + PULSES_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

    // A command is usable only with a non-zero pattern and a non-zero duty.
    function automatic logic cmd_is_legal(input logic pat_nonzero,
                                          input logic [DUTY_W-1:0] duty);
        return pat_nonzero && (duty != '0);
    endfunction

endpackage

// File: rtl/pwm_cmd_sequencer_if.sv
// Command push bus between the control layer (master) and the sequencer (slave).
interface pwm_cmd_if import pwm_seq_pkg::*; #(
    parameter int PAT_WIDTH = 8
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [PAT_WIDTH-1:0] cmd_pat;
    logic [DUTY_W-1:0]    cmd_duty;
    logic [DESSERT_W-1:0] cmd_dessert;
    logic [PULSES_W-1:0]  cmd_pulses;

    modport master (
        output cmd_valid, cmd_pat, cmd_duty, cmd_dessert, cmd_pulses,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_pat, cmd_duty, cmd_dessert, cmd_pulses,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_cmd_sequencer_fifo.sv
// Small synchronous command FIFO with flush. The ready flag is registered
// and held low during reset so the upstream sees no room until reset ends.
module pwm_cmd_fifo #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             ready,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (level != LVL_W'(DEPTH));
    assign do_pop  = pop  && !flush && (level != '0);
    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);

    // Next occupancy: flush wins, a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (do_push && !do_pop) begin
            level_next = level + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_next = level - LVL_W'(1);
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally on the power-of-two depth; ready tracks next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            level <= level_next;
            ready <= (level_next != LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/pwm_cmd_sequencer.sv
// Command sequencer in front of pattern_pwm: queues job descriptors, launches
// them one at a time with a clean pwm_en discipline, and tracks completion.
module pwm_cmd_sequencer import pwm_seq_pkg::*; #(
    parameter int PAT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          seq_en,
    pwm_cmd_if.slave                      cmd,
    input  logic                          stop_req,
    input  logic                          abort,
    input  logic                          err_clr,
    input  logic                          pwm_busy_i,
    output logic                          pwm_en_o,
    output logic [PAT_WIDTH-1:0]          pat_o,
    output logic [DUTY_W-1:0]             duty_o,
    output logic [DESSERT_W-1:0]          dessert_o,
    output logic [PULSES_W-1:0]           pulses_o,
    output logic                          done,
    output logic                          running,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    err
);

    localparam int CMD_W = PAT_WIDTH + CMD_FIXED_W;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    seq_state_t           state;
    logic [TMR_W-1:0]     timer;
    logic                 handshake;
    logic                 cmd_legal;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_ready;
    logic                 timeout_hit;
    logic [CMD_W-1:0]     wr_word;
    logic [CMD_W-1:0]     rd_word;
    logic [PAT_WIDTH-1:0] rd_pat;
    logic [DUTY_W-1:0]    rd_duty;
    logic [DESSERT_W-1:0] rd_dessert;
    logic [PULSES_W-1:0]  rd_pulses;

    assign cmd.cmd_ready = fifo_ready;
    assign handshake     = cmd.cmd_valid && fifo_ready;
    assign cmd_legal     = cmd_is_legal(|cmd.cmd_pat, cmd.cmd_duty);
    assign fifo_push     = handshake && cmd_legal;
    assign fifo_pop      = (state == ST_IDLE) && seq_en && !fifo_empty && !abort;
    assign wr_word       = {cmd.cmd_pat, cmd.cmd_duty, cmd.cmd_dessert, cmd.cmd_pulses};
    assign {rd_pat, rd_duty, rd_dessert, rd_pulses} = rd_word;
    assign running       = (state != ST_IDLE);
    assign timeout_hit   = (state == ST_START) && !abort && !pwm_busy_i &&
                           (timer >= TMR_W'(BUSY_TIMEOUT - 1));

    pwm_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (abort),
        .wr_data (wr_word),
        .rd_data (rd_word),
        .level   (fifo_level),
        .ready   (fifo_ready),
        .empty   (fifo_empty)
    );

    // Sticky error flags; a clear only drops bits from earlier cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 2'b00;
        end else begin
            err <= (err_clr ? 2'b00 : err) | {timeout_hit, handshake && !cmd_legal};
        end
    end

    // Job FSM: pop, settle, raise enable, watch busy, then report completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pwm_en_o  <= 1'b0;
            timer     <= '0;
            done      <= 1'b0;
            pat_o     <= '0;
            duty_o    <= '0;
            dessert_o <= '0;
            pulses_o  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        pat_o     <= rd_pat;
                        duty_o    <= rd_duty;
                        dessert_o <= rd_dessert;
                        pulses_o  <= rd_pulses;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        pwm_en_o <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        pwm_en_o <= 1'b1;
                        timer    <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (abort) begin
                        pwm_en_o <= 1'b0;
                        state    <= ST_DRAIN;
                    end else if (pwm_busy_i) begin
                        if (pulses_o != '0) begin
                            pwm_en_o <= 1'b0;
                            state    <= ST_DRAIN;
                        end else begin
                            state    <= ST_HOLD;
                        end
                    end else if (timeout_hit) begin
                        pwm_en_o <= 1'b0;
                        done     <= 1'b1;
                        timer    <= TMR_W'(BUSY_TIMEOUT);
                        state    <= ST_IDLE;
                    end else begin
                        timer    <= timer + TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (stop_req || abort) begin
                        pwm_en_o <= 1'b0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pwm_busy_i) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    pwm_en_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Self-checking bench for pwm_cmd_sequencer with a behavioural pattern_pwm busy model.
module tb_pwm_cmd_sequencer;
    import pwm_seq_pkg::*;

    localparam int PAT_WIDTH    = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int BUSY_TIMEOUT = 15;

    typedef struct {
        logic        valid;
        logic        clr;
        logic [7:0]  pat;
        logic [7:0]  duty;
        logic [15:0] dessert;
        logic [7:0]  pulses;
        logic        store;
        logic [2:0]  exp_level;
        logic [1:0]  exp_err;
        logic        exp_ready;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        seq_en = 1'b0;
    logic        stop_req = 1'b0;
    logic        abort = 1'b0;
    logic        err_clr = 1'b0;
    logic        pwm_busy_i;
    logic        pwm_en_o;
    logic [7:0]  pat_o;
    logic [7:0]  duty_o;
    logic [15:0] dessert_o;
    logic [7:0]  pulses_o;
    logic        done;
    logic        running;
    logic [2:0]  fifo_level;
    logic [1:0]  err;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    int          launch_count = 0;
    logic        prev_en = 1'b0;
    logic [39:0] sb [$];
    vec_t        vecs [8];

    bit          busy_model_en = 1'b1;
    logic        model_busy;
    logic        model_inf;
    int          model_cnt;

    pwm_cmd_if #(.PAT_WIDTH(PAT_WIDTH)) cmd_if ();

    pwm_cmd_sequencer #(
        .PAT_WIDTH    (PAT_WIDTH),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq_en     (seq_en),
        .cmd        (cmd_if),
        .stop_req   (stop_req),
        .abort      (abort),
        .err_clr    (err_clr),
        .pwm_busy_i (pwm_busy_i),
        .pwm_en_o   (pwm_en_o),
        .pat_o      (pat_o),
        .duty_o     (duty_o),
        .dessert_o  (dessert_o),
        .pulses_o   (pulses_o),
        .done       (done),
        .running    (running),
        .fifo_level (fifo_level),
        .err        (err)
    );

    always #5 clk = ~clk;

    // pattern_pwm stand-in: busy one edge after enable, 4 cycles per pulse,
    // infinite jobs stop one edge after enable falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_inf  <= 1'b0;
            model_cnt  <= 0;
        end else if (!busy_model_en) begin
            model_busy <= 1'b0;
        end else if (!model_busy) begin
            if (pwm_en_o) begin
                model_busy <= 1'b1;
                model_inf  <= (pulses_o == 8'd0);
                model_cnt  <= int'(pulses_o) * 4;
            end
        end else if (model_inf) begin
            if (!pwm_en_o) model_busy <= 1'b0;
        end else if (model_cnt <= 1) begin
            model_busy <= 1'b0;
        end else begin
            model_cnt <= model_cnt - 1;
        end
    end

    assign pwm_busy_i = model_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Launch monitor: every rising enable pops the scoreboard and checks parameters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pwm_en_o && !prev_en) begin
                launch_count++;
                if (sb.size() == 0) begin
                    check("unexpected_launch", 64'(pat_o), 64'hDEAD);
                end else begin
                    check("launch_params", 64'({pat_o, duty_o, dessert_o, pulses_o}), 64'(sb.pop_front()));
                end
            end
            if (done) done_count++;
        end
        prev_en = pwm_en_o;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input logic lvl, input int budget,
                            output int cycles, output bit ok);
        logic s;
        cycles = 0;
        ok = 1'b0;
        while (!ok && cycles < budget) begin
            step();
            cycles++;
            case (which)
                0:       s = pwm_en_o;
                1:       s = pwm_busy_i;
                default: s = done;
            endcase
            if (s === lvl) ok = 1'b1;
        end
    endtask

    task automatic push_cmd(input logic [7:0] pat, input logic [7:0] duty,
                            input logic [15:0] dessert, input logic [7:0] pulses,
                            input bit store);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_pat     = pat;
        cmd_if.cmd_duty    = duty;
        cmd_if.cmd_dessert = dessert;
        cmd_if.cmd_pulses  = pulses;
        if (store) sb.push_back({pat, duty, dessert, pulses});
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        err_clr = v.clr;
        if (v.valid) begin
            push_cmd(v.pat, v.duty, v.dessert, v.pulses, v.store);
        end else begin
            step();
        end
        err_clr = 1'b0;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check($sformatf("vec%0d_level", idx), 64'(fifo_level), 64'(v.exp_level));
        check($sformatf("vec%0d_err", idx), 64'(err), 64'(v.exp_err));
        check($sformatf("vec%0d_ready", idx), 64'(cmd_if.cmd_ready), 64'(v.exp_ready));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 64'(pwm_en_o), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_running"}, 64'(running), 64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_ready"}, 64'(cmd_if.cmd_ready), 64'd0);
        check({tag, "_params"}, 64'({pat_o, duty_o, dessert_o, pulses_o}), 64'd0);
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  c;
        bit  ok;
        int  d0;
        int  l0;

        //            valid clr pat    duty   dess    pul   store lvl   err    rdy
        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'd5, 16'd3, 8'd1, 1'b0, 3'd0, 2'b01, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'h11, 8'd0, 16'd3, 8'd1, 1'b0, 3'd0, 2'b01, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'd0, 16'd0, 8'd0, 1'b0, 3'd0, 2'b00, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'hA1, 8'd1, 16'd2, 8'd1, 1'b1, 3'd1, 2'b00, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'hA2, 8'd2, 16'd0, 8'd2, 1'b1, 3'd2, 2'b00, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'hA3, 8'd1, 16'd1, 8'd3, 1'b1, 3'd3, 2'b00, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'hA4, 8'd3, 16'd0, 8'd1, 1'b1, 3'd4, 2'b00, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'hA5, 8'd1, 16'd0, 8'd1, 1'b0, 3'd4, 2'b00, 1'b0};

        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_pat     = '0;
        cmd_if.cmd_duty    = '0;
        cmd_if.cmd_dessert = '0;
        cmd_if.cmd_pulses  = '0;

        $display("[TB] reset state");
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        #9 rst_n = 1'b1;
        step();
        check("ready_after_reset", 64'(cmd_if.cmd_ready), 64'd1);

        $display("[TB] table: illegal commands, err_clr, queue fill");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        $display("[TB] drain queue in order");
        d0 = done_count;
        seq_en = 1'b1;
        for (int i = 0; i < 800 && done_count < d0 + 4; i++) step();
        check("queue_done_pulses", 64'(done_count - d0), 64'd4);
        check("queue_sb_empty", 64'(sb.size()), 64'd0);
        check("queue_level_empty", 64'(fifo_level), 64'd0);

        $display("[TB] finite job timing");
        push_cmd(8'b0000_0101, 8'd2, 16'd3, 8'd2, 1'b1);
        wait_sig(0, 1'b1, 10, c, ok);
        check("fin_en_rise_ok", 64'(ok), 64'd1);
        check("fin_en_rise_delay", 64'(c), 64'd2);
        wait_sig(1, 1'b1, 10, c, ok);
        check("fin_busy_rise_ok", 64'(ok), 64'd1);
        check("fin_en_before_fall", 64'(pwm_en_o), 64'd1);
        step();
        check("fin_en_low_after_busy", 64'(pwm_en_o), 64'd0);
        wait_sig(1, 1'b0, 40, c, ok);
        check("fin_busy_fall_ok", 64'(ok), 64'd1);
        check("fin_done_not_yet", 64'(done), 64'd0);
        step();
        check("fin_done_pulse", 64'(done), 64'd1);
        step();
        check("fin_done_one_cycle", 64'(done), 64'd0);
        check("fin_err", 64'(err), 64'd0);
        check("fin_idle", 64'(running), 64'd0);

        $display("[TB] infinite job with stop_req");
        push_cmd(8'h3C, 8'd1, 16'd2, 8'd0, 1'b1);
        wait_sig(1, 1'b1, 10, c, ok);
        check("inf_busy_ok", 64'(ok), 64'd1);
        repeat (100) step();
        check("inf_en_held", 64'(pwm_en_o), 64'd1);
        check("inf_running", 64'(running), 64'd1);
        d0 = done_count;
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        check("inf_en_fall", 64'(pwm_en_o), 64'd0);
        wait_sig(1, 1'b0, 3, c, ok);
        check("inf_busy_fall_ok", 64'(ok), 64'd1);
        step();
        step();
        check("inf_done_count", 64'(done_count - d0), 64'd1);

        $display("[TB] simultaneous push and pop");
        seq_en = 1'b0;
        push_cmd(8'h33, 8'd1, 16'd0, 8'd1, 1'b1);
        check("pp_level_one", 64'(fifo_level), 64'd1);
        d0 = done_count;
        seq_en = 1'b1;
        push_cmd(8'h34, 8'd1, 16'd0, 8'd1, 1'b1);
        check("pp_level_unchanged", 64'(fifo_level), 64'd1);
        for (int i = 0; i < 200 && done_count < d0 + 2; i++) step();
        check("pp_done_count", 64'(done_count - d0), 64'd2);

        $display("[TB] start timeout");
        busy_model_en = 1'b0;
        push_cmd(8'h0F, 8'd1, 16'd0, 8'd1, 1'b1);
        wait_sig(0, 1'b1, 10, c, ok);
        check("to_en_rise_ok", 64'(ok), 64'd1);
        d0 = done_count;
        wait_sig(0, 1'b0, 40, c, ok);
        check("to_en_high_cycles", 64'(c), 64'd15);
        check("to_done", 64'(done), 64'd1);
        check("to_err", 64'(err), 64'b10);
        check("to_idle", 64'(running), 64'd0);
        step();
        check("to_single_done", 64'(done_count - d0), 64'd1);
        busy_model_en = 1'b1;

        $display("[TB] err_clr versus same-cycle event");
        err_clr = 1'b1;
        push_cmd(8'h00, 8'd4, 16'd0, 8'd1, 1'b0);
        err_clr = 1'b0;
        check("errclr_same_cycle", 64'(err), 64'b01);
        check("errclr_not_stored", 64'(fifo_level), 64'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("errclr_cleared", 64'(err), 64'd0);

        $display("[TB] abort during HOLD");
        seq_en = 1'b0;
        push_cmd(8'h81, 8'd1, 16'd1, 8'd0, 1'b1);
        push_cmd(8'h82, 8'd1, 16'd1, 8'd2, 1'b1);
        push_cmd(8'h83, 8'd1, 16'd1, 8'd1, 1'b1);
        check("ab_level_three", 64'(fifo_level), 64'd3);
        seq_en = 1'b1;
        wait_sig(1, 1'b1, 20, c, ok);
        check("ab_busy_ok", 64'(ok), 64'd1);
        repeat (5) step();
        check("ab_level_two", 64'(fifo_level), 64'd2);
        d0 = done_count;
        l0 = launch_count;
        abort = 1'b1;
        step();
        abort = 1'b0;
        sb.delete();
        check("ab_level_flushed", 64'(fifo_level), 64'd0);
        check("ab_en_low", 64'(pwm_en_o), 64'd0);
        repeat (40) step();
        check("ab_done_count", 64'(done_count - d0), 64'd1);
        check("ab_no_relaunch", 64'(launch_count - l0), 64'd0);
        check("ab_idle", 64'(running), 64'd0);

        $display("[TB] reset mid-job");
        push_cmd(8'hF0, 8'd1, 16'd0, 8'd5, 1'b1);
        wait_sig(0, 1'b1, 10, c, ok);
        check("rst_job_started", 64'(ok), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        sb.delete();
        seq_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
